// File: rtl/haar_synthesis.sv
// -----------------------------------------------------------------------------
// haar_synthesis
//   Inverse (synthesis) stage of the one-level Haar filterbank. Takes a serial
//   stream of LF/HF coefficient pairs and emits the reconstructed pixel pair
//   serially, p0 first and then p1.
//
//   Forward transform being undone:
//     LF = floor((p0 + p1) / 2)
//     HF = (floor((p1 - p0) / 2) + 2^(IB-1)) mod 2^IB
//   Reconstruction (signed, IB+2 bits, each result clamped to [0, 2^IB-1]):
//     d  = HF - 2^(IB-1)
//     p0 = LF - d
//     p1 = LF + d
//   p0 is exact for analysis-produced pairs. p1 can be one low when p1-p0 was
//   odd, because analysis throws that LSB away.
//
//   Handshake (both sides): a transfer happens on a rising clock edge where
//   valid && ready. A source keeps its data stable while valid && !ready.
//   This block keeps pixel_out/pixel_index stable while pixel_valid &&
//   !pixel_ready.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   coeff_in      in   [IB] coefficient value
//   coeff_region  in   region tag of coeff_in: 0 = LF, 1 = HF
//   coeff_valid   in   coeff_in/coeff_region are valid
//   coeff_ready   out  block accepts a coefficient this cycle
//   pixel_out     out  [IB] reconstructed pixel
//   pixel_index   out  0 = p0, 1 = p1
//   pixel_valid   out  pixel_out/pixel_index are valid
//   pixel_ready   in   downstream accepts pixel_out this cycle
//   region_error  out  registered one-cycle pulse on a region-sequence error
// -----------------------------------------------------------------------------
module haar_synthesis #(
    parameter int IB = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [IB-1:0] coeff_in,
    input  logic          coeff_region,
    input  logic          coeff_valid,
    output logic          coeff_ready,
    output logic [IB-1:0] pixel_out,
    output logic          pixel_index,
    output logic          pixel_valid,
    input  logic          pixel_ready,
    output logic          region_error
);

    localparam int SW = IB + 2;
    localparam logic signed [SW-1:0] HALF = SW'(2 ** (IB - 1));

    typedef enum logic [1:0] {
        GET_LF = 2'd0,
        GET_HF = 2'd1,
        OUT_P0 = 2'd2,
        OUT_P1 = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IB-1:0] l_reg;
    logic [IB-1:0] p0_reg;
    logic [IB-1:0] p1_reg;

    logic          coeff_accept;
    logic          pixel_accept;
    logic          load_l;
    logic          load_p;
    logic          error_next;

    logic signed [SW-1:0] l_ext;
    logic signed [SW-1:0] d_ext;
    logic signed [SW-1:0] p0_raw;
    logic signed [SW-1:0] p1_raw;

    // Non-negative values above 2^IB-1 have a bit set in [SW-2:IB]; the sign
    // bit flags the negative side.
    function automatic logic [IB-1:0] clamp(input logic signed [SW-1:0] v);
        if (v[SW-1]) begin
            return '0;
        end else if (v[SW-2:IB] != '0) begin
            return '1;
        end else begin
            return v[IB-1:0];
        end
    endfunction

    // Output-side decodes depend on state and registers only.
    assign coeff_ready  = (state == GET_LF) || (state == GET_HF);
    assign pixel_valid  = (state == OUT_P0) || (state == OUT_P1);
    assign pixel_index  = (state == OUT_P1);
    assign pixel_out    = (state == OUT_P1) ? p1_reg : p0_reg;

    assign coeff_accept = coeff_valid && coeff_ready;
    assign pixel_accept = pixel_valid && pixel_ready;

    // Reconstruction from the stored LF and the HF currently on the input.
    assign l_ext  = $signed({2'b00, l_reg});
    assign d_ext  = $signed({2'b00, coeff_in}) - HALF;
    assign p0_raw = l_ext - d_ext;
    assign p1_raw = l_ext + d_ext;

    always_comb begin
        state_next = state;
        load_l     = 1'b0;
        load_p     = 1'b0;
        error_next = 1'b0;
        case (state)
            GET_LF: begin
                if (coeff_accept) begin
                    if (!coeff_region) begin
                        load_l     = 1'b1;
                        state_next = GET_HF;
                    end else begin
                        // HF with no LF before it: drop it.
                        error_next = 1'b1;
                    end
                end
            end
            GET_HF: begin
                if (coeff_accept) begin
                    if (coeff_region) begin
                        load_p     = 1'b1;
                        state_next = OUT_P0;
                    end else begin
                        // Second LF in a row: resync on the newest one.
                        load_l     = 1'b1;
                        error_next = 1'b1;
                    end
                end
            end
            OUT_P0: begin
                if (pixel_accept) begin
                    state_next = OUT_P1;
                end
            end
            OUT_P1: begin
                if (pixel_accept) begin
                    state_next = GET_LF;
                end
            end
            default: begin
                state_next = GET_LF;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= GET_LF;
            l_reg        <= '0;
            p0_reg       <= '0;
            p1_reg       <= '0;
            region_error <= 1'b0;
        end else begin
            state        <= state_next;
            region_error <= error_next;
            if (load_l) begin
                l_reg <= coeff_in;
            end
            if (load_p) begin
                p0_reg <= clamp(p0_raw);
                p1_reg <= clamp(p1_raw);
            end
        end
    end

endmodule
